// File: rtl/branch_predictor_2bc_pkg.sv
// Shared constants for the 2-bit-counter branch predictor: counter encodings,
// FSM state codes and indexing-mode selectors.
package branch_predictor_2bc_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [0:0] INIT = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;

endpackage

// File: rtl/branch_predictor_2bc_sat_counter2.sv
// Combinational next-value function for a 2-bit saturating counter.
module sat_counter2
   import branch_predictor_2bc_pkg::*;
(
   input  logic [1:0] count,
   input  logic       taken,
   output logic [1:0] count_nxt
);

   always_comb begin
      count_nxt = count;
      if (taken) begin
         if (count != ST)
            count_nxt = count + 2'd1;
      end else begin
         if (count != SNT)
            count_nxt = count - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor_2bc.sv
// Pattern history table of 2-bit saturating counters with bimodal or gshare
// indexing, initialised by a hardware sweep after reset or flush.
module branch_predictor_2bc
   import branch_predictor_2bc_pkg::*;
#(
   parameter int         IDX_W    = 4,
   parameter int         HIST_W   = 4,
   parameter int         MODE     = MODE_BIMODAL,
   parameter logic [1:0] INIT_VAL = WT
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Flush,
   input  logic [IDX_W-1:0] LookupPC,
   output logic             Prediction,
   output logic [IDX_W-1:0] LookupIdx,
   input  logic             En,
   input  logic [IDX_W-1:0] UpdateIdx,
   input  logic             UpdateTaken,
   output logic             Ready
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [0:0]        state;
   logic [IDX_W-1:0]  sweep;
   logic [HIST_W-1:0] ghr;
   logic [1:0]        pht [DEPTH];
   logic [1:0]        cnt_nxt;
   logic              do_upd;

   assign Ready  = (state == RUN);
   assign do_upd = Ready && En && !Flush;

   // Gshare folds the zero-extended history into the low index bits.
   assign LookupIdx  = (MODE == MODE_GSHARE) ? (LookupPC ^ IDX_W'(ghr)) : LookupPC;
   assign Prediction = Ready ? pht[LookupIdx][1] : 1'b1;

   sat_counter2 u_sat (
      .count     (pht[UpdateIdx]),
      .taken     (UpdateTaken),
      .count_nxt (cnt_nxt)
   );

   // Table storage carries no reset; the sweep owns initialisation.
   always_ff @(posedge Clock) begin
      if (state == INIT)
         pht[sweep] <= INIT_VAL;
      else if (do_upd)
         pht[UpdateIdx] <= cnt_nxt;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= INIT;
         sweep <= '0;
         ghr   <= '0;
      end else if (Flush) begin
         state <= INIT;
         sweep <= '0;
         ghr   <= '0;
      end else if (state == INIT) begin
         sweep <= sweep + 1'b1;
         if (sweep == {IDX_W{1'b1}})
            state <= RUN;
      end else if (En && MODE == MODE_GSHARE) begin
         // Truncating cast drops the oldest bit; also correct for HIST_W = 1.
         ghr <= HIST_W'({ghr, UpdateTaken});
      end
   end

endmodule

// File: tb/tb_branch_predictor_2bc.sv
// Directed bench for branch_predictor_2bc: one bimodal and one gshare instance
// share stimulus and are compared each cycle against a table-level model.
module tb_branch_predictor_2bc;

   localparam int IDX_W = 4;
   localparam int HIST_W = 4;
   localparam int DEPTH = 16;

   logic             Clock = 1'b0;
   logic             Reset = 1'b0;
   logic             Flush = 1'b0;
   logic [IDX_W-1:0] LookupPC = '0;
   logic             En = 1'b0;
   logic [IDX_W-1:0] UpdateIdx = '0;
   logic             UpdateTaken = 1'b0;
   logic             pred [2];
   logic [IDX_W-1:0] lidx [2];
   logic             rdy  [2];

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   always #5 Clock = ~Clock;

   branch_predictor_2bc #(.IDX_W(IDX_W), .HIST_W(HIST_W), .MODE(0), .INIT_VAL(2'b10)) dut_bim (
      .Clock(Clock), .Reset(Reset), .Flush(Flush), .LookupPC(LookupPC),
      .Prediction(pred[0]), .LookupIdx(lidx[0]), .En(En), .UpdateIdx(UpdateIdx),
      .UpdateTaken(UpdateTaken), .Ready(rdy[0]));

   branch_predictor_2bc #(.IDX_W(IDX_W), .HIST_W(HIST_W), .MODE(1), .INIT_VAL(2'b10)) dut_gsh (
      .Clock(Clock), .Reset(Reset), .Flush(Flush), .LookupPC(LookupPC),
      .Prediction(pred[1]), .LookupIdx(lidx[1]), .En(En), .UpdateIdx(UpdateIdx),
      .UpdateTaken(UpdateTaken), .Ready(rdy[1]));

   // Model: counters as plain integers, history as an integer, and the
   // number of init cycles still owed before predictions become valid.
   int m_cnt [2][DEPTH];
   int m_ghr [2] = '{0, 0};
   int m_left [2] = '{DEPTH, DEPTH};

   always @(posedge Clock or negedge Reset) begin
      for (int m = 0; m < 2; m++) begin
         if (!Reset) begin
            m_left[m] = DEPTH;
            m_ghr[m]  = 0;
         end else if (m_left[m] > 0) begin
            m_cnt[m][DEPTH - m_left[m]] = 2;
            m_left[m] = Flush ? DEPTH : m_left[m] - 1;
            if (Flush) m_ghr[m] = 0;
         end else if (Flush) begin
            m_left[m] = DEPTH;
            m_ghr[m]  = 0;
         end else if (En) begin
            if (UpdateTaken) m_cnt[m][UpdateIdx] = (m_cnt[m][UpdateIdx] >= 3) ? 3 : m_cnt[m][UpdateIdx] + 1;
            else             m_cnt[m][UpdateIdx] = (m_cnt[m][UpdateIdx] <= 0) ? 0 : m_cnt[m][UpdateIdx] - 1;
            if (m == 1) m_ghr[m] = ((m_ghr[m] * 2) + int'(UpdateTaken)) % (2 ** HIST_W);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (check_en) begin
         for (int m = 0; m < 2; m++) begin
            int e_idx;
            int e_rdy;
            e_rdy = (m_left[m] == 0) ? 1 : 0;
            e_idx = (m == 1) ? (int'(LookupPC) ^ m_ghr[m]) : int'(LookupPC);
            chk($sformatf("ready[%0d]", m), 32'(rdy[m]), 32'(e_rdy));
            chk($sformatf("lookup_idx[%0d]", m), 32'(lidx[m]), 32'(e_idx));
            chk($sformatf("prediction[%0d]", m), 32'(pred[m]),
                e_rdy == 0 ? 32'd1 : 32'(m_cnt[m][e_idx] >= 2));
         end
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic upd(input int idx, input bit t);
      En = 1'b1;
      UpdateIdx = IDX_W'(idx);
      UpdateTaken = t;
      step();
      En = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (rdy[0] !== 1'b1 && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic all_weakly_taken(input string tag);
      for (int pc = 0; pc < DEPTH; pc++) begin
         LookupPC = IDX_W'(pc);
         #1;
         chk({tag, "_pred_bim"}, 32'(pred[0]), 32'd1);
         chk({tag, "_idx_gsh"}, 32'(lidx[1]), 32'(pc));
         chk({tag, "_pred_gsh"}, 32'(pred[1]), 32'd1);
      end
      chk({tag, "_model_cnt"}, 32'(m_cnt[0][9]), 32'd2);
      #1;
   endtask

   initial begin
      int n;
      #1;
      check_en = 1'b1;
      repeat (2) step();
      chk("reset_ready", 32'(rdy[0]), 32'd0);
      chk("reset_pred", 32'(pred[0]), 32'd1);
      Reset = 1'b1;
      wait_ready(n);
      chk("init_cycles", 32'(n), 32'd16);
      all_weakly_taken("post_init");

      // Bimodal saturation on index 5.
      LookupPC = 4'd5;
      upd(5, 0);
      chk("idx5_wnt", 32'(pred[0]), 32'd0);
      upd(5, 0);
      upd(5, 0);
      chk("idx5_snt_sat", 32'(pred[0]), 32'd0);
      chk("idx5_model", 32'(m_cnt[0][5]), 32'd0);
      upd(5, 1);
      chk("idx5_back_wnt", 32'(pred[0]), 32'd0);
      upd(5, 1);
      chk("idx5_back_wt", 32'(pred[0]), 32'd1);

      // Read-during-write on index 7.
      upd(7, 0);
      LookupPC = 4'd7;
      En = 1'b1;
      UpdateIdx = 4'd7;
      UpdateTaken = 1'b1;
      #1;
      chk("rdw_old", 32'(pred[0]), 32'd0);
      step();
      En = 1'b0;
      chk("rdw_new", 32'(pred[0]), 32'd1);

      // Flush beats a simultaneous update.
      Flush = 1'b1;
      En = 1'b1;
      UpdateIdx = 4'd7;
      UpdateTaken = 1'b0;
      step();
      Flush = 1'b0;
      En = 1'b0;
      chk("flush_ready_low", 32'(rdy[0]), 32'd0);
      wait_ready(n);
      chk("flush_init_cycles", 32'(n), 32'd16);
      all_weakly_taken("post_flush");

      // Gshare history T,T,N,T.
      upd(1, 1);
      upd(2, 1);
      upd(3, 0);
      upd(4, 1);
      LookupPC = 4'b0011;
      #1;
      chk("gshare_idx", 32'(lidx[1]), 32'b1110);
      chk("bimodal_idx", 32'(lidx[0]), 32'b0011);
      chk("gshare_model_ghr", 32'(m_ghr[1]), 32'b1101);

      // Reset mid-sweep, with En activity during both sweeps.
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      En = 1'b1;
      UpdateIdx = 4'd2;
      UpdateTaken = 1'b0;
      repeat (9) step();
      Reset = 1'b0;
      #1;
      chk("midsweep_ready", 32'(rdy[0]), 32'd0);
      step();
      step();
      Reset = 1'b1;
      wait_ready(n);
      En = 1'b0;
      chk("midsweep_init_cycles", 32'(n), 32'd16);
      all_weakly_taken("post_midsweep");

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
